echo_mix_stage: RTL
===================

Name: echo_mix_stage

Overview:
- Output stage placed directly downstream of the delay line.
- Combines the dry input sample with the delayed (wet) sample: y = dry + wet*gain, saturated.
- The gain is ramped per accepted sample so that level changes do not produce zipper noise.
- Two-stage pipeline with valid/ready handshakes on both sides, so it can sit between the delay line and the codec/serializer.

Parameters:
- DATA_WIDTH, 32: signed sample width of dry, wet and y.
- GAIN_WIDTH, 8: unsigned gain width; gain value g means g/2^GAIN_WIDTH (0 .. 255/256).
- RAMP_STEP, 8: maximum change of the working gain per accepted sample.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- dry  in  DATA_WIDTH  signed direct sample.
- wet  in  DATA_WIDTH  signed delayed sample from the delay line output.
- in_valid  in  1  dry/wet pair valid.
- in_ready  out  1  stage can accept a pair this cycle.
- gain  in  GAIN_WIDTH  new target gain.
- gain_load  in  1  single-cycle strobe; latches gain into the target register.
- bypass  in  1  when high, output equals dry (sampled with the input).
- y  out  DATA_WIDTH  signed mixed result.
- out_valid  out  1  y valid.
- out_ready  in  1  consumer accepts y.
- ramp_busy  out  1  high while working gain != target gain.

Behaviour:
- Reset (rst=1 at a CLK edge) forces the following; reset mid-operation discards in-flight samples:
  - y=0, out_valid=0, ramp_busy=0.
  - Stage-1 valid=0, working gain=0, target gain=0.
- Advance rule: adv = !out_valid || out_ready. in_ready = adv (combinational). When adv=0 every pipeline register holds.
- Accept: in_valid && in_ready.
- Stage 1, on accept:
  - prod = signed(wet) * {1'b0, gain_cur}, full width DATA_WIDTH+GAIN_WIDTH+1.
  - Registers dry and bypass. Stage-1 valid <= accept.
- Stage 2, on adv:
  - scaled = prod >>> GAIN_WIDTH (arithmetic shift; floor toward -inf).
  - sum = dry + scaled, computed in DATA_WIDTH+1 bits.
  - Saturate sum to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - y <= bypass ? dry : saturated sum. out_valid <= stage-1 valid.
- Latency: exactly 2 cycles from accept to out_valid when out_ready stays high. Throughput is 1 sample/cycle.
- Ordering: no drop, no duplication.
- Stall bubble: with out_ready=0, at most 2 samples are held (one in stage 1, one in the output register).
- gain_load: target <= gain on that edge. It may arrive at any time, including mid-ramp, which retargets immediately.
- Ramp: on each accept, gain_cur moves toward target by min(RAMP_STEP, |target-gain_cur|). It never overshoots.
  - No change occurs without an accept.
  - A sample accepted on a given edge uses the gain_cur value before that edge's step.
- Simultaneous gain_load and accept: the sample uses the old gain_cur; the step goes toward the new target.
- ramp_busy = (gain_cur != target), registered-derived with no combinational path from gain.
- Bypass: does not freeze the ramp, and has the same latency as the mixed path.
- Gain = 0: y = dry exactly, because prod = 0.

Test Plan:
- Reset: hold rst 2 cycles with random inputs.
  - Required: y=0, out_valid=0, in_ready=1, ramp_busy=0.
  - Assert rst mid-ramp; required: gain_cur=0 and out_valid=0 on the next cycle.
- Ramp: gain_load with gain=128, then stream samples.
  - Required: ramp_busy clears after exactly 16 accepts. With no accepts, gain_cur stays unchanged.
  - Then dry=100, wet=200 -> y=200, with out_valid exactly 2 cycles after accept.
- Saturation, gain 255 settled: dry=0x7FFFFFF0, wet=0x7FFFFFFF -> y=0x7FFFFFFF.
- Saturation, gain 128: dry=0x80000000, wet=-256 -> y=0x80000000.
- Rounding: gain 128, dry=10, wet=-1 -> y=9 (floor); wet=+1 -> y=10.
- Backpressure: out_ready=0 while driving 4 back-to-back samples A..D.
  - Required: only A,B accepted, in_ready=0 afterwards, y holds A.
  - Release out_ready -> A,B,C,D delivered in order, each exactly once.
- Bypass and retarget:
  - bypass=1 with gain 255, dry=-5, wet=1000 -> y=-5 after 2 cycles.
  - gain_load of 0 while ramping up to 200 -> gain_cur reverses direction on the next accept with no overshoot.

Source files
------------

// File: rtl/echo_mix_stage_if.sv
// echo_mix_stage_if
// Bundles the sample streams and gain control of echo_mix_stage.
//   dry, wet, in_valid, in_ready  : input stream (dry/wet pair)
//   y, out_valid, out_ready       : output stream (mixed sample)
//   gain, gain_load, bypass       : control inputs
//   ramp_busy                     : working gain still moving toward target
//   gain_cur                      : working gain, exposed for observability
// Modports: slave = the mixing stage, master = whoever drives it.
interface echo_mix_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int GAIN_WIDTH = 8
);
    logic signed [DATA_WIDTH-1:0] dry;
    logic signed [DATA_WIDTH-1:0] wet;
    logic                         in_valid;
    logic                         in_ready;
    logic [GAIN_WIDTH-1:0]        gain;
    logic                         gain_load;
    logic                         bypass;
    logic signed [DATA_WIDTH-1:0] y;
    logic                         out_valid;
    logic                         out_ready;
    logic                         ramp_busy;
    logic [GAIN_WIDTH-1:0]        gain_cur;

    modport slave (
        input  dry, wet, in_valid, gain, gain_load, bypass, out_ready,
        output in_ready, y, out_valid, ramp_busy, gain_cur
    );

    modport master (
        output dry, wet, in_valid, gain, gain_load, bypass, out_ready,
        input  in_ready, y, out_valid, ramp_busy, gain_cur
    );
endinterface

// File: rtl/echo_mix_stage.sv
// echo_mix_stage
// Output stage after the delay line: y = sat(dry + wet * gain_cur / 2^GAIN_WIDTH).
// The working gain ramps toward the loaded target by at most RAMP_STEP per
// accepted sample to avoid zipper noise. Two register stages:
//   stage 1: wet * gain_cur product, dry and bypass captured
//   stage 2: shift, add, saturate (or pass dry when bypassed) into y
// Ports:
//   CLK  : system clock, rising edge
//   rst  : synchronous active-high reset, discards in-flight samples
//   io   : echo_mix_stage_if.slave (streams, gain control, status)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. valid never depends on ready; once raised, the producer keeps
// data stable until the transfer. Here in_ready = !out_valid || out_ready,
// so the whole pipeline advances together and holds completely otherwise.
module echo_mix_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int GAIN_WIDTH = 8,
    parameter int RAMP_STEP  = 8
) (
    input logic           CLK,
    input logic           rst,
    echo_mix_stage_if.slave io
);
    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam logic [GAIN_WIDTH-1:0] STEP = GAIN_WIDTH'(RAMP_STEP);
    localparam logic signed [PW-1:0] SAT_MAX =
        {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN =
        {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] Y_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] Y_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic                         adv;
    logic                         accept;

    logic [GAIN_WIDTH-1:0]        gain_cur;
    logic [GAIN_WIDTH-1:0]        gain_tgt;
    logic [GAIN_WIDTH-1:0]        tgt_eff;
    logic [GAIN_WIDTH-1:0]        diff;
    logic [GAIN_WIDTH-1:0]        gain_next;

    logic signed [PW-1:0]         prod;
    logic signed [PW-1:0]         s1_prod;
    logic signed [DATA_WIDTH-1:0] s1_dry;
    logic                         s1_bypass;
    logic                         s1_valid;

    logic signed [PW-1:0]         scaled;
    logic signed [PW-1:0]         sum;
    logic signed [DATA_WIDTH-1:0] mix;
    logic signed [DATA_WIDTH-1:0] y_q;
    logic                         out_valid_q;

    assign adv    = !out_valid_q || io.out_ready;
    assign accept = io.in_valid && adv;

    // Gain is treated as unsigned by prefixing a zero bit before the signed
    // multiply; the full-width product cannot overflow PW bits.
    assign prod = PW'($signed(io.wet)) * PW'($signed({1'b0, gain_cur}));

    // A gain_load on the same edge as an accept retargets this step already;
    // the sample itself still uses the pre-step gain_cur captured in prod.
    always_comb begin
        tgt_eff   = io.gain_load ? io.gain : gain_tgt;
        diff      = '0;
        gain_next = gain_cur;
        if (tgt_eff > gain_cur) begin
            diff      = tgt_eff - gain_cur;
            gain_next = gain_cur + ((diff > STEP) ? STEP : diff);
        end else if (tgt_eff < gain_cur) begin
            diff      = gain_cur - tgt_eff;
            gain_next = gain_cur - ((diff > STEP) ? STEP : diff);
        end
    end

    // The sum is formed at product width; dry + scaled always fits in
    // DATA_WIDTH+1 bits, so the wider add gives the same value and the
    // saturation compare sees it exactly.
    always_comb begin
        scaled = s1_prod >>> GAIN_WIDTH;
        sum    = PW'(s1_dry) + scaled;
        if (sum > SAT_MAX) begin
            mix = Y_MAX;
        end else if (sum < SAT_MIN) begin
            mix = Y_MIN;
        end else begin
            mix = sum[DATA_WIDTH-1:0];
        end
        if (s1_bypass) begin
            mix = s1_dry;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            gain_cur    <= '0;
            gain_tgt    <= '0;
            s1_valid    <= 1'b0;
            s1_prod     <= '0;
            s1_dry      <= '0;
            s1_bypass   <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else begin
            if (io.gain_load) begin
                gain_tgt <= io.gain;
            end
            if (accept) begin
                gain_cur <= gain_next;
            end
            if (adv) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_prod   <= prod;
                    s1_dry    <= io.dry;
                    s1_bypass <= io.bypass;
                end
                out_valid_q <= s1_valid;
                y_q         <= mix;
            end
        end
    end

    assign io.in_ready  = adv;
    assign io.y         = y_q;
    assign io.out_valid = out_valid_q;
    assign io.ramp_busy = (gain_cur != gain_tgt);
    assign io.gain_cur  = gain_cur;
endmodule
